// File: rtl/wb_sram_ctrl.sv
// Wishbone classic slave driving an external asynchronous 16-bit SRAM.
// Every request runs a fixed strobe sequence with programmable wait states.
// An address outside the SRAM window is answered with a single-cycle error.
// All outputs are registered. Their next values are decoded from next_state,
// so the SRAM pins change on the same edge as the state does.
module wb_sram_ctrl #(
   parameter int AB_WIDTH = 18,
   parameter int WB_AW    = 24,
   parameter int WAIT_RD  = 1,
   parameter int WAIT_WR  = 1
) (
   input  logic                clk_i,
   input  logic                rst_n_i,
   input  logic                CYC_I,
   input  logic                STB_I,
   input  logic                WE_I,
   input  logic [WB_AW-1:0]    ADR_I,
   input  logic [1:0]          SEL_I,
   input  logic [15:0]         DAT_I,
   output logic [15:0]         DAT_O,
   output logic                ACK_O,
   output logic                ERR_O,
   output logic [AB_WIDTH-1:0] sram_addr_o,
   output logic [15:0]         sram_dat_o,
   input  logic [15:0]         sram_dat_i,
   output logic                sram_dat_oe_o,
   output logic                sram_ncs_o,
   output logic                sram_noe_o,
   output logic                sram_nwe_o,
   output logic [1:0]          sram_bsel_o
);

   typedef enum logic [2:0] {
      S_IDLE, S_RD, S_WSU, S_WP, S_WH, S_DONE, S_ERR
   } state_t;

   state_t      state, next_state;
   logic [3:0]  cnt, next_cnt;
   logic [1:0]  sel_q, sel_n;
   logic        req, out_of_range, accept, sram_active;

   assign req          = CYC_I && STB_I;
   // Any byte-address bit above the SRAM word address selects the error path.
   assign out_of_range = (ADR_I >> (AB_WIDTH + 1)) != '0;
   assign accept       = (state == S_IDLE) && (next_state == S_RD || next_state == S_WSU);
   assign sel_n        = accept ? SEL_I : sel_q;
   assign sram_active  = next_state inside {S_RD, S_WSU, S_WP, S_WH};

   // State register and wait counter.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         // NOTE: sequential state is written with non-blocking assignments so every flop samples pre-edge values.
         state <= S_IDLE;
         cnt   <= '0;
      end else begin
         state <= next_state;
         cnt   <= next_cnt;
      end
   end

   // Next-state and wait-counter decode.
   always_comb begin
      // NOTE: defaults first so every path assigns every signal and no latch is inferred.
      next_state = state;
      next_cnt   = cnt;
      case (state)
         S_IDLE: begin
            if (req) begin
               if (out_of_range) begin
                  next_state = S_ERR;
               end else if (WE_I) begin
                  next_state = S_WSU;
               end else begin
                  next_state = S_RD;
                  next_cnt   = 4'(WAIT_RD);
               end
            end
         end
         S_RD: begin
            if (cnt == 4'd0) next_state = S_DONE;
            else             next_cnt   = cnt - 4'd1;
         end
         S_WSU: begin
            next_state = S_WP;
            next_cnt   = 4'(WAIT_WR);
         end
         S_WP: begin
            if (cnt == 4'd0) next_state = S_WH;
            else             next_cnt   = cnt - 4'd1;
         end
         S_WH:           next_state = S_DONE;
         S_DONE, S_ERR:  next_state = S_IDLE;
         default:        next_state = S_IDLE;
      endcase
   end

   // Registered SRAM strobes, latched request fields and Wishbone responses.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         sel_q         <= '0;
         sram_addr_o   <= '0;
         sram_dat_o    <= '0;
         sram_ncs_o    <= 1'b1;
         sram_noe_o    <= 1'b1;
         sram_nwe_o    <= 1'b1;
         sram_dat_oe_o <= 1'b0;
         sram_bsel_o   <= '0;
         DAT_O         <= '0;
         ACK_O         <= 1'b0;
         ERR_O         <= 1'b0;
      end else begin
         if (accept) begin
            sram_addr_o <= ADR_I[AB_WIDTH:1];
            sram_dat_o  <= DAT_I;
         end
         sel_q         <= sel_n;
         sram_ncs_o    <= !sram_active;
         sram_noe_o    <= !(next_state == S_RD);
         sram_nwe_o    <= !(next_state == S_WP);
         sram_dat_oe_o <= next_state inside {S_WSU, S_WP, S_WH};
         sram_bsel_o   <= sram_active ? sel_n : 2'b00;
         // Sample read data on the last RD cycle; unselected lanes read as zero.
         if (state == S_RD && cnt == 4'd0) begin
            DAT_O <= {sel_q[1] ? sram_dat_i[15:8] : 8'h00,
                      sel_q[0] ? sram_dat_i[7:0]  : 8'h00};
         end
         // A master that has dropped the cycle gets no response.
         ACK_O <= (next_state == S_DONE) && req;
         ERR_O <= (next_state == S_ERR)  && req;
      end
   end

endmodule

// File: tb/tb_wb_sram_ctrl.sv
// Directed bench for wb_sram_ctrl.
// Two instances are used: the default timing, and WAIT_RD=3 / WAIT_WR=0.
// Read data is predicted from a reference memory and queued when a read is issued.
module tb_wb_sram_ctrl;

   localparam int AB = 18;
   localparam int AW = 24;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic          we, cyc1, stb1, cyc2, stb2;
   logic [AW-1:0] adr;
   logic [1:0]    sel;
   logic [15:0]   wdat;

   logic [15:0]   dat_o1, sdo1, sdi1, dat_o2, sdo2, sdi2;
   logic          ack1, err1, oe1, ncs1, noe1, nwe1;
   logic          ack2, err2, oe2, ncs2, noe2, nwe2;
   logic [AB-1:0] addr1, addr2;
   logic [1:0]    bsel1, bsel2;

   wb_sram_ctrl dut (
      .clk_i(clk), .rst_n_i(rst_n), .CYC_I(cyc1), .STB_I(stb1), .WE_I(we),
      .ADR_I(adr), .SEL_I(sel), .DAT_I(wdat), .DAT_O(dat_o1), .ACK_O(ack1),
      .ERR_O(err1), .sram_addr_o(addr1), .sram_dat_o(sdo1), .sram_dat_i(sdi1),
      .sram_dat_oe_o(oe1), .sram_ncs_o(ncs1), .sram_noe_o(noe1),
      .sram_nwe_o(nwe1), .sram_bsel_o(bsel1)
   );

   wb_sram_ctrl #(.WAIT_RD(3), .WAIT_WR(0)) dut2 (
      .clk_i(clk), .rst_n_i(rst_n), .CYC_I(cyc2), .STB_I(stb2), .WE_I(we),
      .ADR_I(adr), .SEL_I(sel), .DAT_I(wdat), .DAT_O(dat_o2), .ACK_O(ack2),
      .ERR_O(err2), .sram_addr_o(addr2), .sram_dat_o(sdo2), .sram_dat_i(sdi2),
      .sram_dat_oe_o(oe2), .sram_ncs_o(ncs2), .sram_noe_o(noe2),
      .sram_nwe_o(nwe2), .sram_bsel_o(bsel2)
   );

   // Asynchronous SRAM model for the default instance: data drives only while selected and enabled.
   logic [15:0] mem1 [0:1023];
   always_comb sdi1 = (!ncs1 && !noe1) ? mem1[addr1[9:0]] : 16'hDEAD;

   // The write commits on the rising edge of nwe while the chip is still selected.
   always @(posedge nwe1) begin
      if (ncs1 === 1'b0) begin
         if (bsel1[1]) mem1[addr1[9:0]][15:8] <= sdo1[15:8];
         if (bsel1[0]) mem1[addr1[9:0]][7:0]  <= sdo1[7:0];
      end
   end

   // Second instance: fixed read pattern, used only for timing checks.
   assign sdi2 = (!ncs2 && !noe2) ? 16'hC0DE : 16'hDEAD;

   // Reference memory and scoreboard of expected read data.
   logic [15:0] ref_mem [0:1023];
   logic [15:0] sb [$];

   int total = 0;
   int bad   = 0;

   // Observations from the most recent transaction.
   int            lat, n_ack, n_err, n_ncs, n_noe, n_nwe, n_viol;
   logic [15:0]   rdat;
   logic [AB-1:0] addr_seen;
   logic [1:0]    bsel_seen;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Runs one request on the selected instance and counts strobe activity per cycle.
   // Cycle k is sampled at the negedge after the k-th rising edge following acceptance.
   // The request fields are scrambled after acceptance to show that they are latched.
   // With abort_at > 0, CYC/STB drop in that cycle and the whole window is observed.
   task automatic run(input bit d2, input bit w, input logic [AW-1:0] a,
                      input logic [1:0] s, input logic [15:0] d, input int abort_at);
      bit c_ncs, c_noe, c_nwe, c_oe, c_ack, c_err;
      lat = 0; n_ack = 0; n_err = 0; n_ncs = 0; n_noe = 0; n_nwe = 0; n_viol = 0;
      rdat = 'x; addr_seen = 'x; bsel_seen = 'x;
      @(negedge clk);
      we = w; adr = a; sel = s; wdat = d;
      if (d2) begin cyc2 = 1'b1; stb2 = 1'b1; end
      else    begin cyc1 = 1'b1; stb1 = 1'b1; end
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (d2) begin
            c_ncs = ncs2; c_noe = noe2; c_nwe = nwe2; c_oe = oe2; c_ack = ack2; c_err = err2;
         end else begin
            c_ncs = ncs1; c_noe = noe1; c_nwe = nwe1; c_oe = oe1; c_ack = ack1; c_err = err1;
         end
         if (!c_ncs) n_ncs++;
         if (!c_noe) n_noe++;
         if (!c_nwe) begin
            n_nwe++;
            addr_seen = d2 ? addr2 : addr1;
            bsel_seen = d2 ? bsel2 : bsel1;
         end
         if ((!c_noe && !c_nwe) || (c_oe && !c_noe)) n_viol++;
         if (c_ack) n_ack++;
         if (c_err) n_err++;
         if ((c_ack || c_err) && lat == 0) begin
            lat  = k;
            rdat = d2 ? dat_o2 : dat_o1;
         end
         if (k == 1) begin
            we = ~w; adr = ~a; sel = ~s; wdat = ~d;
         end
         if (k == abort_at || c_ack || c_err) begin
            cyc1 = 1'b0; stb1 = 1'b0; cyc2 = 1'b0; stb2 = 1'b0;
         end
         if (abort_at == 0 && (c_ack || c_err)) break;
      end
      cyc1 = 1'b0; stb1 = 1'b0; cyc2 = 1'b0; stb2 = 1'b0;
   endtask

   task automatic do_write(input logic [AW-1:0] a, input logic [1:0] s, input logic [15:0] d,
                           input int abort_at);
      if (s[1]) ref_mem[a[10:1]][15:8] = d[15:8];
      if (s[0]) ref_mem[a[10:1]][7:0]  = d[7:0];
      run(1'b0, 1'b1, a, s, d, abort_at);
   endtask

   task automatic do_read(input string tag, input logic [AW-1:0] a, input logic [1:0] s);
      logic [15:0] r, exp;
      r = ref_mem[a[10:1]];
      sb.push_back({s[1] ? r[15:8] : 8'h00, s[0] ? r[7:0] : 8'h00});
      run(1'b0, 1'b0, a, s, 16'h0000, 0);
      check({tag, "_ack"}, 32'(n_ack), 1);
      exp = sb.pop_front();
      check({tag, "_data"}, 32'(rdat), 32'(exp));
   endtask

   initial begin
      we = 1'b0; cyc1 = 1'b0; stb1 = 1'b0; cyc2 = 1'b0; stb2 = 1'b0;
      adr = '0; sel = '0; wdat = '0;
      for (int i = 0; i < 1024; i++) begin
         mem1[i]    = 16'h0000;
         ref_mem[i] = 16'h0000;
      end
      mem1[8]    = 16'hBEEF;
      ref_mem[8] = 16'hBEEF;

      // Reset state.
      repeat (3) @(negedge clk);
      check("rst_strobes", 32'({ncs1, noe1, nwe1, oe1, bsel1}), 'b111000);
      check("rst_resp",    32'({ack1, err1}), 0);
      check("rst_dat_o",   32'(dat_o1), 0);
      check("rst_addr",    32'(addr1), 0);
      check("rst_sram_dat", 32'(sdo1), 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Plain read of a preloaded word.
      do_read("rd1", 24'h000010, 2'b11);
      check("rd1_lat",  32'(lat), 3);
      check("rd1_noe",  32'(n_noe), 2);
      check("rd1_ncs",  32'(n_ncs), 2);
      check("rd1_viol", 32'(n_viol), 0);
      @(negedge clk);
      check("rd1_after", 32'({ncs1, noe1, nwe1, oe1, bsel1, ack1}), 'b1110000);

      // Full-word write and readback.
      do_write(24'h000100, 2'b11, 16'h1234, 0);
      check("wr1_lat",  32'(lat), 5);
      check("wr1_ack",  32'(n_ack), 1);
      check("wr1_nwe",  32'(n_nwe), 2);
      check("wr1_ncs",  32'(n_ncs), 4);
      check("wr1_addr", 32'(addr_seen), 'h080);
      check("wr1_viol", 32'(n_viol), 0);
      @(negedge clk);
      check("wr1_mem",  32'(mem1[10'h080]), 'h1234);
      do_read("rb1", 24'h000100, 2'b11);

      // Upper-byte write, then reads with different lane selects.
      do_write(24'h000100, 2'b10, 16'hAA55, 0);
      check("wr2_bsel", 32'(bsel_seen), 'b10);
      check("wr2_lat",  32'(lat), 5);
      do_read("rb2", 24'h000100, 2'b11);
      do_read("rb3", 24'h000100, 2'b01);
      do_read("rb4_sel0", 24'h000100, 2'b00);

      // Address beyond the SRAM window.
      run(1'b0, 1'b0, 24'h080000, 2'b11, 16'h0000, 0);
      check("err_lat", 32'(lat), 1);
      check("err_cnt", 32'(n_err), 1);
      check("err_ack", 32'(n_ack), 0);
      check("err_ncs", 32'(n_ncs), 0);
      @(negedge clk);
      check("err_after", 32'(err1), 0);

      // Master abort during the write pulse: the write still completes, unacknowledged.
      do_write(24'h000100, 2'b11, 16'h5A5A, 2);
      check("abt_ack", 32'(n_ack), 0);
      check("abt_nwe", 32'(n_nwe), 2);
      check("abt_ncs", 32'(n_ncs), 4);
      check("abt_mem", 32'(mem1[10'h080]), 'h5A5A);
      do_read("abt_rb", 24'h000100, 2'b11);

      // Alternate timing instance.
      run(1'b1, 1'b0, 24'h000010, 2'b11, 16'h0000, 0);
      check("t2_rd_lat",  32'(lat), 5);
      check("t2_rd_noe",  32'(n_noe), 4);
      check("t2_rd_data", 32'(rdat), 'hC0DE);
      run(1'b1, 1'b1, 24'h000010, 2'b11, 16'h1111, 0);
      check("t2_wr_lat",  32'(lat), 4);
      check("t2_wr_nwe",  32'(n_nwe), 1);
      check("t2_wr_ncs",  32'(n_ncs), 3);

      // Reset asserted in the middle of a read.
      @(negedge clk);
      we = 1'b0; adr = 24'h000010; sel = 2'b11;
      cyc2 = 1'b1; stb2 = 1'b1;
      repeat (2) @(negedge clk);
      check("mid_in_rd", 32'({ncs2, noe2}), 0);
      rst_n = 1'b0;
      #1;
      check("mid_strobes", 32'({ncs2, noe2, nwe2, oe2, bsel2}), 'b111000);
      check("mid_dat_o",   32'(dat_o2), 0);
      check("mid_ack",     32'({ack2, err2}), 0);
      cyc2 = 1'b0; stb2 = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("mid_after", 32'({ack2, ncs2}), 'b01);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/wb_sram_ctrl.md
Name: wb_sram_ctrl

Overview:
Wishbone classic slave that converts m68k-side bus cycles into strobe sequences for an external asynchronous 16-bit SRAM (256k x 16 by default).
- Sits between the Wishbone interconnect and the SRAM pins; it is the initiator counterpart of the SRAM device.
- Generates chip select, output enable, write enable and byte-lane selects with parameterised wait states.
- Returns ACK_O on completion, or ERR_O for addresses outside the SRAM window.

Parameters:
AB_WIDTH, 18, SRAM word-address width.
WB_AW, 24, Wishbone byte-address width; ADR_I[0] is ignored.
WAIT_RD, 1, extra read cycles after the first OE cycle before data is sampled (0..15).
WAIT_WR, 1, extra WE-low cycles beyond one (0..15).

Ports:
clk_i  in  1  system clock, all logic on rising edge.
rst_n_i  in  1  asynchronous active-low reset.
CYC_I  in  1  Wishbone cycle.
STB_I  in  1  Wishbone strobe.
WE_I  in  1  1 = write.
ADR_I  in  WB_AW  byte address.
SEL_I  in  2  byte selects; [1] = D15:8, [0] = D7:0.
DAT_I  in  16  write data.
DAT_O  out  16  read data, registered.
ACK_O  out  1  cycle complete.
ERR_O  out  1  address out of range.
sram_addr_o  out  AB_WIDTH  word address = ADR_I[AB_WIDTH:1].
sram_dat_o  out  16  write data to SRAM.
sram_dat_i  in  16  read data from SRAM.
sram_dat_oe_o  out  1  1 = drive SRAM data bus (for the pad tristate).
sram_ncs_o  out  1  chip select, active low.
sram_noe_o  out  1  output enable, active low.
sram_nwe_o  out  1  write enable, active low.
sram_bsel_o  out  2  byte-lane enables, active high.

Behaviour:
- Reset (async, rst_n_i=0):
  - State goes to IDLE.
  - ncs, noe, nwe = 1; bsel = 0; dat_oe = 0.
  - ACK_O = 0, ERR_O = 0, DAT_O = 0, sram_addr_o = 0, sram_dat_o = 0.
  - Reset asserted mid-operation aborts immediately with no ACK or ERR.
- All outputs are registered; there are no combinational paths from Wishbone inputs to outputs.
- IDLE:
  - On CYC_I & STB_I, evaluate the address.
  - If ADR_I[WB_AW-1:AB_WIDTH+1] != 0, go to ERR.
  - Otherwise latch address, SEL_I, DAT_I and WE_I, load the wait counter, and go to RD (WE_I=0) or WSU (WE_I=1).
- RD:
  - ncs = 0, noe = 0, bsel = latched SEL.
  - Stays WAIT_RD+1 cycles.
  - On the last cycle, capture sram_dat_i into DAT_O; unselected byte lanes are written as 0x00.
  - Then go to DONE.
- WSU (write setup, 1 cycle): ncs = 0, nwe = 1, dat_oe = 1, bsel valid.
- WP (write pulse): nwe = 0 for WAIT_WR+1 cycles; address and data held stable.
- WH (write hold, 1 cycle): nwe = 1, ncs = 0, dat_oe = 1. Then go to DONE.
- DONE (1 cycle):
  - All SRAM strobes inactive, dat_oe = 0.
  - ACK_O = 1 only if CYC_I & STB_I are still high; otherwise ACK is suppressed.
  - Always returns to IDLE.
- ERR (1 cycle): ERR_O = 1 (gated by CYC_I & STB_I the same way); no SRAM strobes; back to IDLE.
- Latency, counted from the edge that samples STB in IDLE:
  - read ACK high in cycle WAIT_RD+2;
  - write ACK high in cycle WAIT_WR+4;
  - error ERR high in cycle 1.
- Back-to-back requests: a new request is sampled in the cycle after DONE/ERR, giving at least one idle cycle, because the master drops STB after ACK.
- Master abort (CYC_I drops mid-op): the SRAM sequence completes unchanged, so a write is never truncated. ACK is suppressed and the block returns to IDLE.
- SEL_I = 0: the full cycle runs with bsel = 0; ACK is given; DAT_O = 0 on read.
- WE_I, ADR_I, SEL_I and DAT_I changes after acceptance are ignored (latched values are used).
- Never assert noe and nwe low together; never assert dat_oe while noe = 0.

Test Plan:
1. Reset, then read ADR_I=0x000010, SEL=11, with the model returning 0xBEEF:
   - ncs/noe low for 2 cycles;
   - ACK in cycle 3;
   - DAT_O = 0xBEEF; all strobes inactive after.
2. Write 0x1234 to ADR_I=0x000100, SEL=11, then read back:
   - sram_addr_o = 0x080;
   - nwe low exactly 2 cycles, bracketed by one setup and one hold cycle with ncs low;
   - ACK in cycle 5; readback = 0x1234.
3. Byte write SEL=10 with DAT_I=0xAA55 over stored 0x1234:
   - bsel = 10;
   - readback SEL=11 returns 0xAA34;
   - read SEL=01 returns 0x0034.
4. ADR_I = 0x080000 (bit 19 set, AB_WIDTH = 18):
   - ERR_O pulses 1 cycle;
   - ncs stays high; no ACK.
5. Master abort: drop CYC/STB during WP:
   - nwe pulse and hold complete;
   - no ACK; the memory holds the new data;
   - the next read is served normally.
6. Timing variants and reset:
   - WAIT_RD=3, WAIT_WR=0: read ACK in cycle 5, write nwe low 1 cycle;
   - rst_n_i low mid-RD: all strobes inactive immediately, DAT_O = 0.
